booth_seq: RTL and testbench

BOOTH_SEQ -- requirements
Module: booth_seq

---
 rtl/booth_seq.sv | 123 ++++++++++++
 tb/tb_booth_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq.sv
// booth_seq: sequential Booth multiplier controller (IDLE/INIT/STEP/DONE).
// Ports: clock, reset (async active-low), ctrl_start, ctrl_abort (only with
// BOOTH_ABORT_EN), prod_lsb {Q0,Q-1} -> prod_we, prod_sel, alu_op, iter,
// busy, ready. Define BOOTH_ABORT_EN to add the abort input.
module booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ctrl_start,
`ifdef BOOTH_ABORT_EN
  input  logic       ctrl_abort,
`endif
  input  logic [1:0] prod_lsb,
  output logic       prod_we,
  output logic [1:0] prod_sel,
  output logic [1:0] alu_op,
  output logic [5:0] iter,
  output logic       busy,
  output logic       ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t     st;
  state_t     nxt;
  logic [5:0] cnt;
  logic       abort;

`ifdef BOOTH_ABORT_EN
  assign abort = ctrl_abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  // Counter holds LAST through DONE and returns to 0 whenever
  // the sequence leaves for IDLE or (re)enters INIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (st == STEP && nxt == STEP) begin
      cnt <= cnt + 6'd1;
    end else if (nxt == IDLE || nxt == INIT) begin
      cnt <= '0;
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: begin
        if (ctrl_start && !abort) nxt = INIT;
      end
      INIT: begin
        nxt = abort ? IDLE : STEP;
      end
      STEP: begin
        if (abort) begin
          nxt = IDLE;
        end else if (cnt == LAST) begin
          nxt = DONE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    prod_we  = 1'b0;
    prod_sel = 2'b00;
    alu_op   = 2'b00;
    busy     = 1'b0;
    ready    = 1'b0;
    unique case (1'b1)
      (st == IDLE): begin
      end
      (st == INIT): begin
        prod_we  = 1'b1;
        prod_sel = 2'b01;
        busy     = 1'b1;
      end
      (st == STEP): begin
        prod_we  = 1'b1;
        prod_sel = 2'b10;
        busy     = 1'b1;
        // Booth pair {Q0,Q-1}: 01 add, 10 subtract, else pass.
        unique case (prod_lsb)
          2'b01:   alu_op = 2'b01;
          2'b10:   alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
      end
      (st == DONE): begin
        ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign iter = cnt;

endmodule

// File: tb/tb_booth_seq.sv
// tb_booth_seq: directed bench for booth_seq at WIDTH=32 and WIDTH=2.
// Abort scenario is exercised when BOOTH_ABORT_EN is defined.
module tb_booth_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] lsb;
  logic       we;
  logic [1:0] sel;
  logic [1:0] alu;
  logic [5:0] iter;
  logic       busy;
  logic       ready;
`ifdef BOOTH_ABORT_EN
  logic       abort;
`endif

  logic       start2;
  logic [1:0] lsb2;
  logic       we2;
  logic [1:0] sel2;
  logic [1:0] alu2;
  logic [5:0] iter2;
  logic       busy2;
  logic       ready2;

  logic [12:0] o32;
  assign o32 = {ready, busy, we, sel, alu, iter};

  int checks;
  int fails;

  booth_seq #(.WIDTH(32)) dut32 (
    .clock      (clk),
    .reset      (rst_n),
    .ctrl_start (start),
`ifdef BOOTH_ABORT_EN
    .ctrl_abort (abort),
`endif
    .prod_lsb   (lsb),
    .prod_we    (we),
    .prod_sel   (sel),
    .alu_op     (alu),
    .iter       (iter),
    .busy       (busy),
    .ready      (ready)
  );

  booth_seq #(.WIDTH(2)) dut2 (
    .clock      (clk),
    .reset      (rst_n),
    .ctrl_start (start2),
`ifdef BOOTH_ABORT_EN
    .ctrl_abort (1'b0),
`endif
    .prod_lsb   (lsb2),
    .prod_we    (we2),
    .prod_sel   (sel2),
    .alu_op     (alu2),
    .iter       (iter2),
    .busy       (busy2),
    .ready      (ready2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL reset_async: got %h want 0", o32);
    end
    tick();
    tick();
    checks++;
    if (o32 !== 13'd0 || busy2 !== 1'b0 || we2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got %h want 0", o32);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL reset_release_idle: got %h want 0", o32);
    end
  endtask

  task automatic test_latency();
    int nbusy;
    nbusy = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) nbusy++;
    checks++;
    if (o32 !== {1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 6'd0}) begin
      fails++;
      $display("FAIL lat_init: got %h want %h", o32,
               {1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 6'd0});
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      if (busy) nbusy++;
      checks++;
      if (o32 !== {1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 6'(k)}) begin
        fails++;
        $display("FAIL lat_step%0d: got %h want %h", k, o32,
                 {1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 6'(k)});
      end
    end
    tick();
    checks++;
    if (o32 !== {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6'd31}) begin
      fails++;
      $display("FAIL lat_done: got %h want %h", o32,
               {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6'd31});
    end
    checks++;
    if (nbusy != 33) begin
      fails++;
      $display("FAIL lat_busy_cycles: got %0d want 33", nbusy);
    end
    tick();
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL lat_idle: got %h want 0", o32);
    end
  endtask

  task automatic test_alu();
    logic [1:0] pv [4];
    logic [1:0] ev [4];
    int c;
    pv = '{2'b01, 2'b10, 2'b00, 2'b11};
    ev = '{2'b01, 2'b10, 2'b00, 2'b00};
    lsb = 2'b01;
    #1;
    checks++;
    if (alu !== 2'b00) begin
      fails++;
      $display("FAIL alu_idle: got %b want 00", alu);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    lsb = 2'b10;
    #1;
    checks++;
    if (alu !== 2'b00) begin
      fails++;
      $display("FAIL alu_init: got %b want 00", alu);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      lsb = pv[i];
      #1;
      checks++;
      if (alu !== ev[i] || iter !== 6'(i)) begin
        fails++;
        $display("FAIL alu_step%0d: got alu=%b iter=%0d want alu=%b iter=%0d",
                 i, alu, iter, ev[i], i);
      end
    end
    lsb = 2'b00;
    c = 0;
    while (!ready && c < 40) begin
      tick();
      c++;
    end
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL alu_finish: got ready=%b want 1", ready);
    end
    tick();
  endtask

  task automatic test_start_held();
    int n_init;
    int n_rdy;
    int both;
    int init_c [2];
    int rdy_c [2];
    n_init = 0;
    n_rdy = 0;
    both = 0;
    init_c = '{0, 0};
    rdy_c = '{0, 0};
    start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      tick();
      if (sel === 2'b01) begin
        if (n_init < 2) init_c[n_init] = c;
        n_init++;
      end
      if (ready === 1'b1) begin
        if (n_rdy < 2) rdy_c[n_rdy] = c;
        n_rdy++;
      end
      if (ready === 1'b1 && busy === 1'b1) both++;
      if (c == 40) start = 1'b0;
    end
    checks++;
    if (n_init != 2 || init_c[0] != 1 || init_c[1] != 36) begin
      fails++;
      $display("FAIL held_inits: got n=%0d at %0d,%0d want n=2 at 1,36",
               n_init, init_c[0], init_c[1]);
    end
    checks++;
    if (n_rdy != 2 || rdy_c[0] != 34 || rdy_c[1] != 69) begin
      fails++;
      $display("FAIL held_ready: got n=%0d at %0d,%0d want n=2 at 34,69",
               n_rdy, rdy_c[0], rdy_c[1]);
    end
    checks++;
    if (both != 0) begin
      fails++;
      $display("FAIL held_ready_busy_overlap: got %0d want 0", both);
    end
  endtask

  task automatic test_reset_mid();
    int nrdy;
    int c;
    nrdy = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      if (ready) nrdy++;
    end
    checks++;
    if (iter !== 6'd10 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: got iter=%0d busy=%b want 10 1", iter, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL rmid_async: got %h want 0", o32);
    end
    tick();
    if (ready) nrdy++;
    tick();
    if (ready) nrdy++;
    checks++;
    if (o32 !== 13'd0 || nrdy != 0) begin
      fails++;
      $display("FAIL rmid_hold: got %h ready=%0d want 0 0", o32, nrdy);
    end
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    checks++;
    if (sel !== 2'b01 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_first_start: got sel=%b busy=%b want 01 1", sel, busy);
    end
    while (!ready && c < 60) begin
      tick();
      c++;
    end
    checks++;
    if (ready !== 1'b1 || c != 34) begin
      fails++;
      $display("FAIL rmid_latency: got %0d want 34", c);
    end
    tick();
  endtask

`ifdef BOOTH_ABORT_EN
  task automatic test_abort();
    int nrdy;
    nrdy = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) tick();
    checks++;
    if (iter !== 6'd5) begin
      fails++;
      $display("FAIL abort_pre: got iter=%0d want 5", iter);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL abort_idle: got %h want 0", o32);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready || busy) nrdy++;
    end
    checks++;
    if (nrdy != 0) begin
      fails++;
      $display("FAIL abort_no_ready: got %0d want 0", nrdy);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (o32 !== 13'd0) begin
      fails++;
      $display("FAIL abort_with_start: got %h want 0", o32);
    end
  endtask
`endif

  task automatic test_width2();
    int nwe;
    int rc;
    int rit;
    nwe = 0;
    rc = 0;
    rit = 0;
    start2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) start2 = 1'b0;
      if (we2) nwe++;
      if (ready2 && rc == 0) begin
        rc = c;
        rit = int'(iter2);
      end
    end
    checks++;
    if (rc != 4 || rit != 1) begin
      fails++;
      $display("FAIL w2_ready: got cycle=%0d iter=%0d want 4 1", rc, rit);
    end
    checks++;
    if (nwe != 3) begin
      fails++;
      $display("FAIL w2_prod_we: got %0d want 3", nwe);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst_n = 1'b1;
    start = 1'b0;
    lsb = 2'b00;
    start2 = 1'b0;
    lsb2 = 2'b00;
`ifdef BOOTH_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_alu();
    test_start_held();
    test_reset_mid();
`ifdef BOOTH_ABORT_EN
    test_abort();
`endif
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
